// File: rtl/m_register_file.sv
// Parametrised register file: combinational read ports, one synchronous write port,
// per-register busy scoreboard with population counter. Optional macro: REGFILE_BYPASS_EN.
module m_register_file #(
   parameter int WIDTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int RD_PORTS = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
   output logic [RD_PORTS*WIDTH-1:0]  rd_data,
   output logic [RD_PORTS-1:0]        rd_busy,
   input  logic                       we,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       issue_en,
   input  logic [ADDR_W-1:0]          issue_addr,
   output logic [ADDR_W:0]            busy_cnt
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [ADDR_W:0]   cnt;

   logic              wr_hit;
   logic              iss_hit;
   logic              set_new;
   logic              clr_old;

   assign wr_hit  = we && (wr_addr != '0);
   assign iss_hit = issue_en && (issue_addr != '0);

   // Counter deltas: a new producer on the written register keeps it busy, so no clear.
   assign set_new = iss_hit && !busy[issue_addr];
   assign clr_old = wr_hit && busy[wr_addr] && !(iss_hit && (issue_addr == wr_addr));

   always_ff @(posedge clk) begin
      if (rst) begin
         mem  <= '{default: '0};
         busy <= '0;
         cnt  <= '0;
      end else begin
         if (wr_hit) begin
            mem[wr_addr]  <= wr_data;
            busy[wr_addr] <= 1'b0;
         end
         if (iss_hit)
            busy[issue_addr] <= 1'b1;
         if (set_new && !clr_old)
            cnt <= cnt + 1'b1;
         else if (clr_old && !set_new)
            cnt <= cnt - 1'b1;
      end
   end

   assign busy_cnt = cnt;

   logic [ADDR_W-1:0] ra;

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      ra      = '0;
      for (int unsigned p = 0; p < RD_PORTS; p++) begin
         ra = rd_addr[p*ADDR_W +: ADDR_W];
         if (ra != '0) begin
            rd_data[p*WIDTH +: WIDTH] = mem[ra];
            rd_busy[p]                = busy[ra];
         end
`ifdef REGFILE_BYPASS_EN
         if (wr_hit && (ra == wr_addr)) begin
            rd_data[p*WIDTH +: WIDTH] = wr_data;
            rd_busy[p]                = 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_m_register_file.sv
// Scoreboard bench for m_register_file: default 32x32/2-port instance plus an 8-bit,
// 8-entry, 3-port instance; expectations queued by stimulus, popped by a negedge monitor.
module tb_m_register_file;

   logic        clk = 1'b0;
   logic        rst;

   logic [9:0]  a_rd_addr;
   logic [63:0] a_rd_data;
   logic [1:0]  a_rd_busy;
   logic        a_we;
   logic [4:0]  a_wr_addr;
   logic [31:0] a_wr_data;
   logic        a_issue_en;
   logic [4:0]  a_issue_addr;
   logic [5:0]  a_busy_cnt;

   logic [8:0]  b_rd_addr;
   logic [23:0] b_rd_data;
   logic [2:0]  b_rd_busy;
   logic        b_we;
   logic [2:0]  b_wr_addr;
   logic [7:0]  b_wr_data;
   logic        b_issue_en;
   logic [2:0]  b_issue_addr;
   logic [3:0]  b_busy_cnt;

   always #5 clk = ~clk;

   m_register_file #(.WIDTH(32), .ADDR_W(5), .RD_PORTS(2)) dut_a (
      .clk(clk), .rst(rst),
      .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
      .we(a_we), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
      .issue_en(a_issue_en), .issue_addr(a_issue_addr), .busy_cnt(a_busy_cnt)
   );

   m_register_file #(.WIDTH(8), .ADDR_W(3), .RD_PORTS(3)) dut_b (
      .clk(clk), .rst(rst),
      .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
      .we(b_we), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
      .issue_en(b_issue_en), .issue_addr(b_issue_addr), .busy_cnt(b_busy_cnt)
   );

   typedef enum {K_ADATA, K_ABUSY, K_ACNT, K_BDATA, K_BBUSY, K_BCNT} kind_t;
   typedef struct {
      kind_t       k;
      int unsigned port;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

`ifdef REGFILE_BYPASS_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   function automatic logic [31:0] actual(kind_t k, int unsigned p);
      logic [31:0] v;
      v = '0;
      case (k)
         K_ADATA: v = a_rd_data[p*32 +: 32];
         K_ABUSY: v = {31'b0, a_rd_busy[p]};
         K_ACNT:  v = {26'b0, a_busy_cnt};
         K_BDATA: v = {24'b0, b_rd_data[p*8 +: 8]};
         K_BBUSY: v = {31'b0, b_rd_busy[p]};
         K_BCNT:  v = {28'b0, b_busy_cnt};
         default: v = '1;
      endcase
      return v;
   endfunction

   // Monitor: samples mid-cycle, when the combinational read outputs are settled.
   always @(negedge clk) begin
      exp_t it;
      logic [31:0] act;
      while (sb.size() > 0) begin
         it  = sb.pop_front();
         act = actual(it.k, it.port);
         checks++;
         if (act !== it.exp) begin
            errors++;
            $display("FAIL %s port%0d: got 0x%0h, expected 0x%0h", it.name, it.port, act, it.exp);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_v(kind_t k, int unsigned p, logic [31:0] v, string n);
      sb.push_back('{k, p, v, n});
   endtask

   task automatic idle_a;
      a_we = 1'b0; a_wr_addr = '0; a_wr_data = '0;
      a_issue_en = 1'b0; a_issue_addr = '0;
   endtask

   task automatic idle_b;
      b_we = 1'b0; b_wr_addr = '0; b_wr_data = '0;
      b_issue_en = 1'b0; b_issue_addr = '0;
   endtask

   task automatic rd_a(input logic [4:0] a0, input logic [4:0] a1);
      a_rd_addr = {a1, a0};
   endtask

   task automatic rd_b(input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
      b_rd_addr = {a2, a1, a0};
   endtask

   initial begin
      rst = 1'b1;
      idle_a(); idle_b();
      rd_a(5'd3, 5'd0); rd_b(3'd0, 3'd0, 3'd0);
      tick(); tick();
      rst = 1'b0;
      expect_v(K_ACNT, 0, 0, "reset_cnt");
      expect_v(K_ADATA, 0, 0, "reset_data");
      expect_v(K_ABUSY, 0, 0, "reset_busy");
      tick();

      // reset clears array and overrides concurrent write/issue
      a_we = 1'b1; a_wr_addr = 5'd14; a_wr_data = 32'd69;
      tick();
      idle_a(); rd_a(5'd14, 5'd21);
      expect_v(K_ADATA, 0, 69, "wr14_pre_rst");
      tick();
      rst = 1'b1;
      a_we = 1'b1; a_wr_addr = 5'd20; a_wr_data = 32'd5;
      a_issue_en = 1'b1; a_issue_addr = 5'd3;
      tick();
      rst = 1'b0; idle_a(); rd_a(5'd14, 5'd3);
      expect_v(K_ADATA, 0, 0, "rst_r14");
      expect_v(K_ABUSY, 1, 0, "rst_busy_r3");
      expect_v(K_ACNT, 0, 0, "rst_cnt");
      tick();
      rd_a(5'd14, 5'd20);
      expect_v(K_ADATA, 1, 0, "rst_drop_wr20");
      tick();

      // two-port write/read
      a_we = 1'b1; a_wr_addr = 5'd14; a_wr_data = 32'd69;
      tick();
      idle_a(); rd_a(5'd14, 5'd21);
      expect_v(K_ADATA, 0, 69, "p0_r14");
      expect_v(K_ADATA, 1, 0, "p1_r21");
      tick();
      a_we = 1'b1; a_wr_addr = 5'd21; a_wr_data = 32'd42; rd_a(5'd0, 5'd0);
      tick();
      idle_a(); rd_a(5'd14, 5'd21);
      expect_v(K_ADATA, 1, 42, "p1_r21_w");
      expect_v(K_ADATA, 0, 69, "p0_r14_keep");
      tick();

      // register zero
      a_we = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'd420;
      a_issue_en = 1'b1; a_issue_addr = 5'd0; rd_a(5'd0, 5'd0);
      tick(); tick();
      idle_a();
      expect_v(K_ADATA, 0, 0, "r0_data");
      expect_v(K_ABUSY, 0, 0, "r0_busy");
      expect_v(K_ACNT, 0, 0, "r0_cnt");
      tick();

      // scoreboard
      a_issue_en = 1'b1; a_issue_addr = 5'd5;
      tick();
      idle_a(); rd_a(5'd5, 5'd6);
      expect_v(K_ABUSY, 0, 1, "iss_r5_busy");
      expect_v(K_ACNT, 0, 1, "iss_r5_cnt");
      tick();
      a_issue_en = 1'b1; a_issue_addr = 5'd6;
      a_we = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'd7; rd_a(5'd0, 5'd0);
      tick();
      idle_a(); rd_a(5'd5, 5'd6);
      expect_v(K_ADATA, 0, 7, "wb_r5_data");
      expect_v(K_ABUSY, 0, 0, "wb_r5_busy");
      expect_v(K_ABUSY, 1, 1, "iss_r6_busy");
      expect_v(K_ACNT, 0, 1, "swap_cnt");
      tick();
      a_issue_en = 1'b1; a_issue_addr = 5'd6;
      a_we = 1'b1; a_wr_addr = 5'd6; a_wr_data = 32'd11; rd_a(5'd0, 5'd0);
      tick();
      idle_a(); rd_a(5'd6, 5'd0);
      expect_v(K_ADATA, 0, 11, "same_r6_data");
      expect_v(K_ABUSY, 0, 1, "same_r6_busy");
      expect_v(K_ACNT, 0, 1, "same_cnt");
      tick();
      a_we = 1'b1; a_wr_addr = 5'd14; a_wr_data = 32'd99;
      tick();
      idle_a(); rd_a(5'd14, 5'd6);
      expect_v(K_ADATA, 0, 99, "nonbusy_wr");
      expect_v(K_ACNT, 0, 1, "nonbusy_cnt");
      tick();

      // bypass
      a_issue_en = 1'b1; a_issue_addr = 5'd9;
      tick();
      idle_a(); rd_a(5'd9, 5'd6);
      expect_v(K_ABUSY, 0, 1, "iss_r9_busy");
      expect_v(K_ACNT, 0, 2, "iss_r9_cnt");
      tick();
      a_we = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'hDEAD; rd_a(5'd9, 5'd6);
      expect_v(K_ADATA, 0, BP ? 32'hDEAD : 32'd0, "bypass_data");
      expect_v(K_ABUSY, 0, BP ? 32'd0 : 32'd1, "bypass_busy");
      expect_v(K_ABUSY, 1, 1, "bypass_other");
      tick();
      idle_a(); rd_a(5'd9, 5'd6);
      expect_v(K_ADATA, 0, 32'hDEAD, "r9_after");
      expect_v(K_ABUSY, 0, 0, "r9_busy_after");
      expect_v(K_ACNT, 0, 1, "r9_cnt_after");
      tick();

      // narrow instance: fill, 3-port reads, issue all
      for (int i = 1; i < 8; i++) begin
         b_we = 1'b1; b_wr_addr = 3'(i); b_wr_data = 8'(8'hF0 + i);
         tick();
      end
      idle_b(); rd_b(3'd1, 3'd2, 3'd3);
      expect_v(K_BDATA, 0, 8'hF1, "b_r1");
      expect_v(K_BDATA, 1, 8'hF2, "b_r2");
      expect_v(K_BDATA, 2, 8'hF3, "b_r3");
      tick();
      rd_b(3'd4, 3'd5, 3'd6);
      expect_v(K_BDATA, 0, 8'hF4, "b_r4");
      expect_v(K_BDATA, 1, 8'hF5, "b_r5");
      expect_v(K_BDATA, 2, 8'hF6, "b_r6");
      tick();
      rd_b(3'd7, 3'd0, 3'd1);
      expect_v(K_BDATA, 0, 8'hF7, "b_r7");
      expect_v(K_BDATA, 1, 8'h00, "b_r0");
      expect_v(K_BDATA, 2, 8'hF1, "b_r1_dup");
      expect_v(K_BCNT, 0, 0, "b_cnt0");
      tick();
      for (int i = 1; i < 8; i++) begin
         b_issue_en = 1'b1; b_issue_addr = 3'(i);
         tick();
      end
      idle_b(); rd_b(3'd7, 3'd3, 3'd0);
      expect_v(K_BCNT, 0, 7, "b_cnt_all");
      expect_v(K_BBUSY, 0, 1, "b_busy7");
      expect_v(K_BBUSY, 1, 1, "b_busy3");
      expect_v(K_BBUSY, 2, 0, "b_busy0");
      tick();
      b_issue_en = 1'b1; b_issue_addr = 3'd7;
      tick();
      idle_b();
      expect_v(K_BCNT, 0, 7, "b_cnt_reissue");
      tick();
      b_we = 1'b1; b_wr_addr = 3'd3; b_wr_data = 8'h33; rd_b(3'd0, 3'd0, 3'd0);
      tick();
      idle_b(); rd_b(3'd3, 3'd7, 3'd0);
      expect_v(K_BCNT, 0, 6, "b_cnt_dec");
      expect_v(K_BBUSY, 0, 0, "b_busy3_clr");
      expect_v(K_BDATA, 0, 8'h33, "b_r3_wr");
      tick();

      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
